// File: rtl/agc_pkg.sv
// Shared fixed-point widths, Chebyshev coefficients and constants for the AGC
// log/exp datapath.
package agc_pkg;

    localparam int IN_W       = 38;
    localparam int IN_FRAC    = 33;
    localparam int OUT_W      = 36;
    localparam int OUT_FRAC   = 28;
    localparam int COEF_W     = 18;
    localparam int COEF_FRAC  = 17;
    localparam int F_W        = 32;
    localparam int K_W        = 7;
    localparam int POS_W      = 6;
    localparam int PIPE_DEPTH = 6;

    // Cubic interpolant of ln(1+f) through the 4 Chebyshev nodes of [0,1), sfix18_En17
    localparam logic signed [COEF_W-1:0] C0 = 18'sd75;
    localparam logic signed [COEF_W-1:0] C1 = 18'sd128615;
    localparam logic signed [COEF_W-1:0] C2 = -18'sd51668;
    localparam logic signed [COEF_W-1:0] C3 = 18'sd13873;

    localparam logic [F_W-1:0] LN2 = 32'hB172_17F8;

    localparam logic [OUT_W-1:0] OUT_ZERO = 36'h8_0000_0000;

endpackage

// File: rtl/agc_lzc.sv
// Combinational leading-one detector: position of the highest set bit plus an
// all-zero flag, shared by the log and exp range-reduction stages.
module agc_lzc
    import agc_pkg::*;
(
    input  logic [IN_W-1:0]  din,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    always_comb begin
        pos = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (din[i]) begin
                pos = POS_W'(i);
            end
        end
    end

    assign zero = ~|din;

endmodule

// File: rtl/log_approx_chebyshev.sv
// Six-stage pipelined ln(x) for ufix38_En33 x using k*ln2 + cubic Chebyshev p(f).
// Define LOG_APPROX_ROUND_EN to round the final En28 conversion instead of truncating.
module log_approx_chebyshev
    import agc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic [IN_W-1:0]  In1,
    input  logic             In1_valid,
    output logic [OUT_W-1:0] Out1,
    output logic             Out1_valid,
    output logic             Zero_flag
);

    localparam int T3_W    = COEF_W + F_W + 2;
    localparam int T4_W    = T3_W + F_W + 2;
    localparam int T5_W    = T4_W + F_W + 2;
    localparam int T5_FRAC = COEF_FRAC + 3 * F_W;
    localparam int SUM_W   = T5_W + 2;
    localparam int DROP    = T5_FRAC - OUT_FRAC;

    logic [POS_W-1:0]        lzc_pos;
    logic                    lzc_zero;

    logic [PIPE_DEPTH-1:0]   valid_sr;

    logic [IN_W-1:0]         x_s1;
    logic [POS_W-1:0]        pos_s1;
    logic                    zero_s1;

    logic [F_W-1:0]          f_s2, f_s3, f_s4;
    logic signed [K_W-1:0]   k_s2, k_s3, k_s4, k_s5;
    logic                    zero_s2, zero_s3, zero_s4, zero_s5;

    logic signed [T3_W-1:0]  t3_s3;
    logic signed [T4_W-1:0]  t4_s4;
    logic signed [T5_W-1:0]  t5_s5;

    logic [IN_W-1:0]         norm;
    logic [F_W-1:0]          f_d;
    logic signed [K_W-1:0]   k_d;
    logic signed [T3_W-1:0]  t3_d;
    logic signed [T4_W-1:0]  t4_d;
    logic signed [T5_W-1:0]  t5_d;
    logic signed [SUM_W-1:0] kln2;
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] round_bias;
    logic [OUT_W-1:0]        out_d;

    agc_lzc u_lzc (
        .din  (In1),
        .pos  (lzc_pos),
        .zero (lzc_zero)
    );

    // Shifting the leading one up to bit IN_W-1 leaves f in the bits just below it
    assign norm = x_s1 << (POS_W'(IN_W - 1) - pos_s1);
    assign f_d  = F_W'(norm >> (IN_W - 1 - F_W));
    assign k_d  = $signed({1'b0, pos_s1}) - K_W'(IN_FRAC);

    // Horner steps keep every product bit; the fraction grows by F_W per stage
    assign t3_d = T3_W'(C3) * T3_W'($signed({1'b0, f_s2})) + (T3_W'(C2) <<< F_W);
    assign t4_d = T4_W'(t3_s3) * T4_W'($signed({1'b0, f_s3})) + (T4_W'(C1) <<< (2 * F_W));
    assign t5_d = T5_W'(t4_s4) * T5_W'($signed({1'b0, f_s4})) + (T5_W'(C0) <<< (3 * F_W));

    assign kln2  = SUM_W'(k_s5) * SUM_W'($signed({1'b0, LN2}));
    assign sum_d = SUM_W'(t5_s5) + (kln2 <<< (T5_FRAC - F_W));

`ifdef LOG_APPROX_ROUND_EN
    // Half an LSB, one less for negatives so exact ties move away from zero
    assign round_bias = sum_d[SUM_W-1] ? ((SUM_W'(1) <<< (DROP - 1)) - SUM_W'(1))
                                       : (SUM_W'(1) <<< (DROP - 1));
`else
    assign round_bias = '0;
`endif

    assign out_d = OUT_W'((sum_d + round_bias) >>> DROP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_sr <= '0;
        end else if (enb) begin
            valid_sr <= {valid_sr[PIPE_DEPTH-2:0], In1_valid};
        end
    end

    assign Out1_valid = valid_sr[PIPE_DEPTH-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_s1    <= '0;
            pos_s1  <= '0;
            zero_s1 <= 1'b0;
            f_s2    <= '0;
            k_s2    <= '0;
            zero_s2 <= 1'b0;
            t3_s3   <= '0;
            f_s3    <= '0;
            k_s3    <= '0;
            zero_s3 <= 1'b0;
            t4_s4   <= '0;
            f_s4    <= '0;
            k_s4    <= '0;
            zero_s4 <= 1'b0;
            t5_s5   <= '0;
            k_s5    <= '0;
            zero_s5 <= 1'b0;
        end else if (enb) begin
            x_s1    <= In1;
            pos_s1  <= lzc_pos;
            zero_s1 <= lzc_zero;
            f_s2    <= f_d;
            k_s2    <= k_d;
            zero_s2 <= zero_s1;
            t3_s3   <= t3_d;
            f_s3    <= f_s2;
            k_s3    <= k_s2;
            zero_s3 <= zero_s2;
            t4_s4   <= t4_d;
            f_s4    <= f_s3;
            k_s4    <= k_s3;
            zero_s4 <= zero_s3;
            t5_s5   <= t5_d;
            k_s5    <= k_s4;
            zero_s5 <= zero_s4;
        end
    end

    // Output only moves for a valid sample so it holds while the pipe is idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            Out1      <= '0;
            Zero_flag <= 1'b0;
        end else if (enb && valid_sr[PIPE_DEPTH-2]) begin
            Out1      <= zero_s5 ? OUT_ZERO : out_d;
            Zero_flag <= zero_s5;
        end
    end

endmodule

// File: tb/tb_log_approx_chebyshev.sv
// Self-checking bench for log_approx_chebyshev: enabled-cycle delay-line model
// with a real-valued ln() reference, plus directed literal vectors.
module tb_log_approx_chebyshev;
    import agc_pkg::*;

    localparam real TOL      = 2.5e-3;
    localparam real IN_SCALE = 8589934592.0;
    localparam real OUT_SCALE = 268435456.0;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enb = 1'b0;
    logic [IN_W-1:0]  In1 = '0;
    logic             In1_valid = 1'b0;
    logic [OUT_W-1:0] Out1;
    logic             Out1_valid;
    logic             Zero_flag;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    logic            pipe_v [PIPE_DEPTH];
    logic [IN_W-1:0] pipe_x [PIPE_DEPTH];

    always #5 clk = ~clk;

    log_approx_chebyshev dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .In1        (In1),
        .In1_valid  (In1_valid),
        .Out1       (Out1),
        .Out1_valid (Out1_valid),
        .Zero_flag  (Zero_flag)
    );

    task automatic check_output(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: %s", name, detail);
        end
    endtask

    task automatic check_eq(input string name, input longint act, input longint exp);
        check_output(name, act == exp, $sformatf("got %0d, required %0d", act, exp));
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        check_output(name, act >= lo && act <= hi,
                     $sformatf("got %0d, required %0d..%0d", act, lo, hi));
    endtask

    task automatic check_ln(input string name, input longint act_raw, input logic [IN_W-1:0] x);
        real want;
        real got;
        real err;
        want = $ln(real'(x) / IN_SCALE);
        got  = real'(act_raw) / OUT_SCALE;
        err  = got - want;
        check_output(name, err <= TOL && err >= -TOL,
                     $sformatf("x=%0d got %0.6f, required %0.6f +/- 0.0025", x, got, want));
    endtask

    function automatic longint out_signed();
        return longint'($signed(Out1));
    endfunction

    // Reference: samples advance one slot per enabled edge, reset empties the line
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_x[i] <= '0;
            end
        end else if (enb) begin
            for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_x[i] <= pipe_x[i-1];
            end
            pipe_v[0] <= In1_valid;
            pipe_x[0] <= In1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check_eq("stream_valid", longint'(Out1_valid), longint'(pipe_v[PIPE_DEPTH-1]));
            if (pipe_v[PIPE_DEPTH-1] && Out1_valid) begin
                if (pipe_x[PIPE_DEPTH-1] == '0) begin
                    check_eq("stream_zero_out", longint'(Out1), longint'(OUT_ZERO));
                    check_eq("stream_zero_flag", longint'(Zero_flag), 1);
                end else begin
                    check_eq("stream_nonzero_flag", longint'(Zero_flag), 0);
                    check_ln("stream_ln", out_signed(), pipe_x[PIPE_DEPTH-1]);
                end
            end
        end
    end

    // One sample, then idle; returns at the negedge after the sixth enabled edge
    task automatic apply_stimulus(input logic [IN_W-1:0] x);
        @(negedge clk);
        In1       = x;
        In1_valid = 1'b1;
        enb       = 1'b1;
        @(negedge clk);
        In1_valid = 1'b0;
        In1       = '0;
        repeat (4) @(negedge clk);
        check_eq("latency_early", longint'(Out1_valid), 0);
        @(negedge clk);
        check_eq("latency_valid", longint'(Out1_valid), 1);
    endtask

    initial begin
        logic [63:0]     r;
        logic [IN_W-1:0] x;
        int              n_en;
        int              cycles;

        repeat (3) @(negedge clk);
        check_eq("reset_out1", longint'(Out1), 0);
        check_eq("reset_valid", longint'(Out1_valid), 0);
        check_eq("reset_zero", longint'(Zero_flag), 0);
        checking = 1'b1;
        reset    = 1'b1;

        apply_stimulus(38'h2_0000_0000);
        check_range("x_one", out_signed(), -671089, 671089);
        check_eq("x_one_zero_flag", longint'(Zero_flag), 0);

        apply_stimulus(38'h4_0000_0000);
        check_range("x_two", out_signed(), 186065279 - 671089, 186065279 + 671089);

        apply_stimulus(38'h0_0000_0001);
        check_range("x_min", out_signed(), -64'sd6140154223 - 671089, -64'sd6140154223 + 671089);

        apply_stimulus(38'h3F_FFFF_FFFF);
        check_range("x_max", out_signed(), 930326397 - 671089, 930326397 + 671089);

        apply_stimulus(38'h0);
        check_eq("x_zero_out", longint'(Out1), longint'(OUT_ZERO));
        check_eq("x_zero_flag", longint'(Zero_flag), 1);
        @(negedge clk);
        check_eq("hold_valid", longint'(Out1_valid), 0);
        check_eq("hold_out", longint'(Out1), longint'(OUT_ZERO));
        check_eq("hold_flag", longint'(Zero_flag), 1);

        apply_stimulus(38'h2_0000_0000);
        check_eq("after_zero_flag", longint'(Zero_flag), 0);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            enb       = ($urandom_range(0, 3) != 0);
            In1_valid = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 9))
                0:       x = '0;
                1:       x = '1;
                default: begin
                    r = {$urandom(), $urandom()};
                    x = r[IN_W-1:0] >> $urandom_range(0, IN_W - 1);
                end
            endcase
            In1 = x;
        end
        @(negedge clk);
        enb       = 1'b1;
        In1_valid = 1'b0;
        repeat (PIPE_DEPTH + 2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            In1       = 38'h1_0000_0000 << i;
            In1_valid = 1'b1;
            @(negedge clk);
        end
        In1_valid = 1'b0;
        reset     = 1'b0;
        enb       = 1'b0;
        @(negedge clk);
        check_eq("midreset_out1", longint'(Out1), 0);
        check_eq("midreset_valid", longint'(Out1_valid), 0);
        reset = 1'b1;
        enb   = 1'b1;
        for (int i = 0; i < PIPE_DEPTH + 2; i++) begin
            @(negedge clk);
            check_eq("midreset_idle", longint'(Out1_valid), 0);
        end

        In1       = 38'h4_0000_0000;
        In1_valid = 1'b1;
        @(negedge clk);
        In1_valid = 1'b0;
        n_en   = 1;
        cycles = 0;
        while (!Out1_valid && cycles < 30) begin
            enb = cycles[0];
            @(negedge clk);
            if (enb) n_en++;
            cycles++;
        end
        check_eq("midreset_first_valid", longint'(Out1_valid), 1);
        check_eq("midreset_latency", longint'(n_en), PIPE_DEPTH);
        check_range("midreset_value", out_signed(), 186065279 - 671089, 186065279 + 671089);

        enb = 1'b1;
        repeat (3) @(negedge clk);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/log_approx_chebyshev.md
LOG_APPROX_CHEBYSHEV -- requirements
Module: log_approx_chebyshev

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset sampled on the rising edge of clk.
REQ-003 SHALL have port enb, input, 1 bit: clock enable; when low, every register holds its value.
REQ-004 SHALL have port In1, input, 38 bits: unsigned ufix38_En33 operand x, which is a power or magnitude estimate.
REQ-005 SHALL have port In1_valid, input, 1 bit: qualifies In1 on any cycle where enb=1.
REQ-006 SHALL have port Out1, output, 36 bits: signed sfix36_En28 result, ln(x).
REQ-007 SHALL have port Out1_valid, output, 1 bit: qualifies Out1.
REQ-008 SHALL have port Zero_flag, output, 1 bit: high alongside Out1_valid when the input sample was 0.

Function
REQ-009 SHALL compute ln(x) = k*ln2 + p(f), where x = (1+f)*2^k, 0 <= f < 1, and k is a signed integer in the range -33..4.
REQ-010 SHALL take p as a cubic Chebyshev-interpolation polynomial for ln(1+f) on [0,1), fitted at the 4 Chebyshev nodes; the package holds c0..c3 as sfix18_En17.
REQ-011 SHALL be a 6-stage pipeline, so In1 sampled on enabled cycle n appears on Out1 at enabled cycle n+6:
- S1: register the input and compute a leading-one position, 6 bits.
- S2: normalise with a barrel shift to f as ufix32_En32, and form k = msb_pos - 33.
- S3: t = c3*f + c2.
- S4: t = t*f + c1.
- S5: t = t*f + c0.
- S6: Out1 = t + k*LN2, with LN2 as ufix32_En32.
REQ-012 SHALL carry In1_valid through a 6-deep valid shift register that advances only when enb=1; Out1_valid is its last bit.
REQ-013 SHALL accept a new sample every enabled cycle; there is no backpressure and no bubbles.
REQ-014 SHALL, for In1 = 0, drive Out1 = 36'h8_0000_0000 (most negative) and Zero_flag = 1 with the same 6-cycle latency.
REQ-015 SHALL use full-precision internal products; each Horner stage keeps at least 34 fractional bits and truncates only at the final conversion to En28.
REQ-016 SHALL guarantee |Out1 - ln(x)| <= 2.5e-3 for every x > 0.
REQ-017 SHALL not overflow: the output range -22.88..3.47 fits sfix36_En28; no saturation logic is needed apart from REQ-014.
REQ-018 SHALL keep Out1 and Zero_flag at their last values while Out1_valid is low; only Out1_valid has meaning when the pipeline is empty.

Reset
REQ-019 SHALL, when reset=0 at a rising clk edge, clear all pipeline data registers to 0, all valid bits to 0, Out1 to 0, Out1_valid to 0 and Zero_flag to 0, regardless of enb.
REQ-020 SHALL discard samples in flight when reset is asserted mid-operation; the first valid output after reset comes from a sample accepted after reset is released.

Configuration
REQ-021 SHALL, when LOG_APPROX_ROUND_EN is defined, round the final En28 conversion to nearest, with ties away from zero (add half an LSB, then truncate); when it is undefined, SHALL truncate toward minus infinity. Latency is the same in both builds.

Structure
REQ-022 SHALL place the following in shared package agc_pkg:
- fixed-point widths: IN_W=38, IN_FRAC=33, OUT_W=36, OUT_FRAC=28;
- coefficients C0..C3;
- LN2;
- PIPE_DEPTH=6.
REQ-023 SHALL implement the leading-one detector as sub-module agc_lzc, which is combinational, 38-bit input, 6-bit position plus a zero flag; the exp block will reuse it for range reduction.

Verification
REQ-024 SHALL drive In1=38'h2_0000_0000 (x=1.0) with In1_valid=1 -> 6 cycles later Out1_valid=1 and |Out1| <= 671089 LSB (0.0025).
REQ-025 SHALL drive In1=38'h4_0000_0000 (x=2.0) -> Out1 within 0.0025 of 0.693147, i.e. raw value about 186065279.
REQ-026 SHALL drive In1=1 (x=2^-33) -> Out1 within 0.0025 of -22.8739; then In1=38'h3F_FFFF_FFFF -> Out1 within 0.0025 of 3.4657.
REQ-027 SHALL drive In1=0 -> Out1=36'h8_0000_0000 and Zero_flag=1 at latency 6; a following sample of x=1.0 -> Zero_flag=0.
REQ-028 SHALL stream back-to-back samples while toggling enb randomly -> the outputs match a reference model in order, with each latency counted in enabled cycles.
REQ-029 SHALL assert reset=0 for one cycle with 3 samples in flight -> Out1_valid stays 0 until 6 enabled cycles after the next accepted sample.
